// File: rtl/gf180mcu_fd_sc_mcu9t5v0__incond.sv
// Pad-input conditioner: synchronizes raw I into CLK, debounces it into Z and flags edges on RISE/FALL.
// Latency SYNC_STAGES+DB_CYCLES edges from a stable I step to Z; no backpressure, free-running every CLK.
module gf180mcu_fd_sc_mcu9t5v0__incond #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic I,
   input  logic EN,
   output logic Z,
   output logic RISE,
   output logic FALL,
   output logic BUSY
);
   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_nxt;
   logic                   z_nxt;
   logic                   rise_nxt;
   logic                   fall_nxt;

   assign s = sync_q[SYNC_STAGES-1];

   // Any cycle where s agrees with Z, or the filter is disabled, discards progress.
   always_comb begin
      cnt_nxt  = '0;
      z_nxt    = Z;
      rise_nxt = 1'b0;
      fall_nxt = 1'b0;
      if (EN && (s != Z)) begin
         if (cnt == CNT_LAST) begin
            z_nxt    = s;
            rise_nxt = s;
            fall_nxt = ~s;
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q <= '0;
         cnt    <= '0;
         Z      <= 1'b0;
         RISE   <= 1'b0;
         FALL   <= 1'b0;
         BUSY   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], I};
         cnt    <= cnt_nxt;
         Z      <= z_nxt;
         RISE   <= rise_nxt;
         FALL   <= fall_nxt;
         BUSY   <= (cnt_nxt != '0);
      end
   end
endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__incond.md
GF180MCU_FD_SC_MCU9T5V0__INCOND -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__incond

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on I, legal range 2..4.
REQ-002 Parameter DB_CYCLES, default 8: synchronized cycles a new level must persist before acceptance, legal range 2..256.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 I  input  1  raw pad-side input net (the antenna-protected net), asynchronous to CLK.
REQ-006 EN  input  1  filter enable; synchronous to CLK.
REQ-007 Z  output  1  debounced, synchronized level of I; registered.
REQ-008 RISE  output  1  one-cycle pulse when Z goes 0->1; registered.
REQ-009 FALL  output  1  one-cycle pulse when Z goes 1->0; registered.
REQ-010 BUSY  output  1  high while a candidate level change is being counted (cnt != 0); registered.

Function
REQ-011 I SHALL pass through a chain of SYNC_STAGES flops; the last stage output is s; no logic between stages.
REQ-012 Counter cnt SHALL be $clog2(DB_CYCLES) bits wide, unsigned, with no wrap-around reachable.
REQ-013 Each edge with EN=1, s==Z: cnt<=0; Z holds; RISE=FALL=0.
REQ-014 Each edge with EN=1, s!=Z, cnt<DB_CYCLES-1: cnt<=cnt+1; Z holds.
REQ-015 Each edge with EN=1, s!=Z, cnt==DB_CYCLES-1: Z<=s, cnt<=0, and RISE (if s=1) or FALL (if s=0) SHALL be 1 for exactly that following cycle.
REQ-016 RISE and FALL SHALL never be 1 in the same cycle and SHALL be 0 in every cycle not covered by REQ-015.
REQ-017 Each edge with EN=0: cnt<=0, Z holds, RISE=FALL=0; the synchronizer chain SHALL keep sampling.
REQ-018 Latency: I steps and stays stable before edge 1 with EN=1 -> s changes after edge SYNC_STAGES, Z changes after edge SYNC_STAGES+DB_CYCLES (10 edges at defaults).
REQ-019 Glitch filtering: any excursion of s lasting fewer than DB_CYCLES consecutive cycles SHALL leave Z unchanged and return cnt to 0 on the first cycle s==Z.
REQ-020 An excursion in progress reverting (s returns to Z) at the same edge cnt would have reached DB_CYCLES-1 SHALL clear cnt; no toggle.
REQ-021 EN deasserted mid-count SHALL discard progress; counting restarts from 0 on re-enable.
REQ-022 BUSY SHALL equal (cnt != 0) as a registered value, updated on the same edge as cnt.
REQ-023 No combinational path SHALL exist from I or EN to any output.

Reset
REQ-024 RST=1 SHALL immediately and asynchronously force all synchronizer flops, cnt, Z, RISE, FALL, BUSY to 0.
REQ-025 RST asserted mid-count or during a RISE/FALL pulse SHALL abort it; no pulse after release until a new full qualification.
REQ-026 After RST deasserts with I=1 held, Z SHALL rise and RISE pulse once after edge SYNC_STAGES+DB_CYCLES (counted from the first edge after release).
REQ-027 Reset release SHALL be treated as synchronous to CLK by the integrator; the block adds no reset synchronizer.

Verification
REQ-028 Defaults, EN=1, reset then I 0->1 before edge 1 held -> Z=1 and RISE=1 for one cycle after edge 10, FALL stays 0, BUSY high after edges 3..9.
REQ-029 Z=1, I pulses low for 7 synchronized cycles -> Z stays 1, no FALL, BUSY returns 0 on the cycle after s returns high; 8 cycles -> Z=0 and FALL pulses once.
REQ-030 I 0->1 held, EN dropped for one cycle at cnt=5 -> cnt cleared, Z rises 8 edges after EN re-asserts, single RISE.
REQ-031 RST asserted when cnt=6 asynchronously between edges -> all outputs 0 immediately; after release with I=1, RISE occurs exactly SYNC_STAGES+DB_CYCLES edges later.
REQ-032 Random I toggling with DB_CYCLES=2 and DB_CYCLES=256, SYNC_STAGES=3 -> scoreboard model matches Z/RISE/FALL/BUSY every cycle; RISE/FALL never coincide and strictly alternate.
